// File: rtl/ram_write_scheduler_pkg.sv
// Shared types and constants for the RAM write scheduler.
// The request struct is sized to the default RAM geometry.
package ram_write_scheduler_pkg;

  localparam int NUM_WR_PORTS = 4;
  localparam int RAM_INDEX    = 4;
  localparam int RAM_WIDTH    = 8;

  typedef struct packed {
    logic [RAM_INDEX-1:0] addr;
    logic [RAM_WIDTH-1:0] data;
  } ram_wr_req_t;

  function automatic logic [2:0] clamp_limit(
    input logic [2:0] lim
  );
    return (lim > 3'd4) ? 3'd4 : lim;
  endfunction

endpackage

// File: rtl/ram_write_scheduler_if.sv
// Enqueue bundle between writeback lanes and the write scheduler.
// All four lanes share one ready.
interface ram_write_scheduler_if #(
  parameter int INDEX = 4,
  parameter int WIDTH = 8
);

  logic [3:0]         enq_valid_i;
  logic [4*INDEX-1:0] enq_addr_i;
  logic [4*WIDTH-1:0] enq_data_i;
  logic               enq_ready_o;

  modport master (
    output enq_valid_i,
    output enq_addr_i,
    output enq_data_i,
    input  enq_ready_o
  );

  modport slave (
    input  enq_valid_i,
    input  enq_addr_i,
    input  enq_data_i,
    output enq_ready_o
  );

endinterface

// File: rtl/ram_wr_lane_compact.sv
// Packs accepted lanes into consecutive queue slots in lane order.
// offset[k] is the slot of lane k relative to tail.
module ram_wr_lane_compact
  import ram_write_scheduler_pkg::*;
(
  input  logic [NUM_WR_PORTS-1:0]      valid,
  input  logic                         ready,
  output logic [NUM_WR_PORTS-1:0]      take,
  output logic [NUM_WR_PORTS-1:0][2:0] offset,
  output logic [2:0]                   accepted
);

  always_comb begin
    take     = valid & {NUM_WR_PORTS{ready}};
    accepted = '0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      offset[k] = accepted;
      accepted  = accepted + {2'b0, take[k]};
    end
  end

endmodule

// File: rtl/ram_write_scheduler.sv
// Circular write queue feeding the four RAM write ports.
// Oldest entry always leaves on the lowest port.
module ram_write_scheduler
  import ram_write_scheduler_pkg::*;
#(
  parameter int INDEX  = RAM_INDEX,
  parameter int WIDTH  = RAM_WIDTH,
  parameter int QDEPTH = 8,
  parameter int QIDX   = 3
) (
  input  logic             clk,
  input  logic             reset,
  ram_write_scheduler_if.slave enq,
  input  logic [2:0]       drain_limit_i,
  output logic             we0_o,
  output logic             we1_o,
  output logic             we2_o,
  output logic             we3_o,
  output logic [INDEX-1:0] addr0wr_o,
  output logic [INDEX-1:0] addr1wr_o,
  output logic [INDEX-1:0] addr2wr_o,
  output logic [INDEX-1:0] addr3wr_o,
  output logic [WIDTH-1:0] data0wr_o,
  output logic [WIDTH-1:0] data1wr_o,
  output logic [WIDTH-1:0] data2wr_o,
  output logic [WIDTH-1:0] data3wr_o,
  output logic [QIDX:0]    count_o,
  output logic             empty_o
);

  localparam logic [QIDX:0] READY_MAX =
    (QIDX+1)'(QDEPTH - NUM_WR_PORTS);

  logic [QIDX-1:0] head;
  logic [QIDX-1:0] tail;
  logic [QIDX:0]   count;
  ram_wr_req_t     mem [QDEPTH];

  logic                              ready;
  logic [NUM_WR_PORTS-1:0]           take;
  logic [NUM_WR_PORTS-1:0][2:0]      offset;
  logic [2:0]                        accepted;
  logic [2:0]                        lim;
  logic [2:0]                        n;
  logic [NUM_WR_PORTS-1:0]           we;
  logic [NUM_WR_PORTS-1:0][INDEX-1:0] wr_addr;
  logic [NUM_WR_PORTS-1:0][WIDTH-1:0] wr_data;
  ram_wr_req_t                       ent;

  // Ready looks only at registered occupancy, never at this cycle's drain.
  assign ready           = (count <= READY_MAX);
  assign enq.enq_ready_o = ready;

  ram_wr_lane_compact u_compact (
    .valid    (enq.enq_valid_i),
    .ready    (ready),
    .take     (take),
    .offset   (offset),
    .accepted (accepted)
  );

  always_comb begin
    lim = clamp_limit(drain_limit_i);
    n   = '0;
    if (!reset) begin
      n = (count < (QIDX+1)'(lim)) ? 3'(count) : lim;
    end
  end

  always_comb begin
    we      = '0;
    wr_addr = '0;
    wr_data = '0;
    ent     = '0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      ent   = mem[head + QIDX'(k)];
      we[k] = (3'(k) < n);
      if (we[k]) begin
        wr_addr[k] = INDEX'(ent.addr);
        wr_data[k] = WIDTH'(ent.data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + QIDX'(n);
      tail  <= tail + QIDX'(accepted);
      count <= count + (QIDX+1)'(accepted)
                     - (QIDX+1)'(n);
    end
  end

  // Payload storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        if (take[k]) begin
          mem[tail + QIDX'(offset[k])] <= '{
            addr: enq.enq_addr_i[k*INDEX +: INDEX],
            data: enq.enq_data_i[k*WIDTH +: WIDTH]
          };
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count <= (QIDX+1)'(QDEPTH));
      assert (QIDX'(tail - head) == count[QIDX-1:0]);
    end
  end

  assign we0_o     = we[0];
  assign we1_o     = we[1];
  assign we2_o     = we[2];
  assign we3_o     = we[3];
  assign addr0wr_o = wr_addr[0];
  assign addr1wr_o = wr_addr[1];
  assign addr2wr_o = wr_addr[2];
  assign addr3wr_o = wr_addr[3];
  assign data0wr_o = wr_data[0];
  assign data1wr_o = wr_data[1];
  assign data2wr_o = wr_data[2];
  assign data3wr_o = wr_data[3];
  assign count_o   = count;
  assign empty_o   = (count == '0);

endmodule

// File: tb/tb_ram_write_scheduler.sv
// Scoreboard bench: stimulus queues expected port writes,
// a negedge monitor pops and compares each asserted write port.
module tb_ram_write_scheduler;

  localparam int INDEX = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] drain_limit = 3'd0;

  logic we0, we1, we2, we3;
  logic [INDEX-1:0] a0, a1, a2, a3;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0] count;
  logic empty;

  ram_write_scheduler_if #(.INDEX(INDEX), .WIDTH(WIDTH)) bus ();

  ram_write_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .enq           (bus),
    .drain_limit_i (drain_limit),
    .we0_o         (we0),
    .we1_o         (we1),
    .we2_o         (we2),
    .we3_o         (we3),
    .addr0wr_o     (a0),
    .addr1wr_o     (a1),
    .addr2wr_o     (a2),
    .addr3wr_o     (a3),
    .data0wr_o     (d0),
    .data1wr_o     (d1),
    .data2wr_o     (d2),
    .data3wr_o     (d3),
    .count_o       (count),
    .empty_o       (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    int addr;
    int data;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] ram_model [16];

  logic [3:0] we_v;
  logic [INDEX-1:0] ad [4];
  logic [WIDTH-1:0] dt [4];

  assign we_v  = {we3, we2, we1, we0};
  assign ad[0] = a0;
  assign ad[1] = a1;
  assign ad[2] = a2;
  assign ad[3] = a3;
  assign dt[0] = d0;
  assign dt[1] = d1;
  assign dt[2] = d2;
  assign dt[3] = d3;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)",
               name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input int a, input int d);
    exp_t e;
    e.port = p;
    e.addr = a;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [3:0] v,
                       input logic [15:0] a,
                       input logic [31:0] d);
    bus.enq_valid_i = v;
    bus.enq_addr_i  = a;
    bus.enq_data_i  = d;
  endtask

  // Monitor: ports are walked low to high, so the model's final
  // value reflects the highest-port-wins rule of the RAM.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (we_v[k]) begin
        ram_model[ad[k]] = dt[k];
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: port %0d addr %0d data %0h, required no write (t=%0t)",
                   k, ad[k], dt[k], $time);
        end else begin
          e = sbq.pop_front();
          if (e.port != k || e.addr != int'(ad[k]) ||
              e.data != int'(dt[k])) begin
            errors++;
            $display("FAIL port_write: got port %0d addr %0d data %0h, required port %0d addr %0d data %0h (t=%0t)",
                     k, ad[k], dt[k], e.port, e.addr, e.data, $time);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with all lanes requesting: nothing may be captured.
    drive(4'hF, 16'h4321, 32'hEEEEEEEE);
    drain_limit = 3'd4;
    repeat (2) cyc();
    @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_ready", int'(bus.enq_ready_o), 1);
    chk("reset_we", int'(we_v), 0);
    cyc();
    reset = 1'b0;
    drive(4'h0, 16'h0, 32'h0);

    repeat (10) begin
      cyc();
      @(negedge clk);
      chk("idle_count", int'(count), 0);
      chk("idle_empty", int'(empty), 1);
      chk("idle_ready", int'(bus.enq_ready_o), 1);
      chk("idle_we", int'(we_v), 0);
    end

    // Full-width enqueue drained in one cycle.
    cyc();
    drive(4'hF, 16'h4321, 32'hA4A3A2A1);
    drain_limit = 3'd4;
    push(0, 1, 'hA1);
    push(1, 2, 'hA2);
    push(2, 3, 'hA3);
    push(3, 4, 'hA4);
    @(negedge clk);
    chk("enq_latency_we", int'(we_v), 0);
    cyc();
    drive(4'h0, 16'h0, 32'h0);
    @(negedge clk);
    chk("full_enq_count", int'(count), 4);
    cyc();
    @(negedge clk);
    chk("full_enq_empty", int'(empty), 1);
    chk("full_enq_count0", int'(count), 0);

    // Sparse lanes, one port per cycle.
    cyc();
    drain_limit = 3'd1;
    drive(4'b0101, 16'h9695, 32'h99669955);
    push(0, 5, 'h55);
    push(0, 6, 'h66);
    cyc();
    drive(4'h0, 16'h0, 32'h0);
    @(negedge clk);
    chk("sparse_count2", int'(count), 2);
    cyc();
    @(negedge clk);
    chk("sparse_count1", int'(count), 1);
    cyc();
    @(negedge clk);
    chk("sparse_empty", int'(empty), 1);

    // Same-address writes in one cycle: youngest must win.
    cyc();
    drain_limit = 3'd4;
    drive(4'b0111, 16'h0777, 32'h00332211);
    push(0, 7, 'h11);
    push(1, 7, 'h22);
    push(2, 7, 'h33);
    cyc();
    drive(4'h0, 16'h0, 32'h0);
    @(negedge clk);
    chk("same_addr_count", int'(count), 3);
    cyc();
    @(negedge clk);
    chk("ram_addr7", int'(ram_model[7]), 'h33);
    chk("same_addr_empty", int'(empty), 1);

    // Fill with drain disabled, then drain across the wrap.
    cyc();
    drain_limit = 3'd0;
    drive(4'hF, 16'hBA98, 32'h83828180);
    cyc();
    drive(4'hF, 16'hFEDC, 32'h87868584);
    @(negedge clk);
    chk("fill_count4", int'(count), 4);
    chk("fill_ready4", int'(bus.enq_ready_o), 1);
    cyc();
    drive(4'hF, 16'h0000, 32'hDEADBEEF);
    @(negedge clk);
    chk("fill_count8", int'(count), 8);
    chk("fill_ready8", int'(bus.enq_ready_o), 0);
    cyc();
    drive(4'h0, 16'h0, 32'h0);
    drain_limit = 3'd4;
    push(0, 8, 'h80);
    push(1, 9, 'h81);
    push(2, 10, 'h82);
    push(3, 11, 'h83);
    @(negedge clk);
    chk("full_ignored_count", int'(count), 8);
    chk("full_ready_no_drain_path", int'(bus.enq_ready_o), 0);
    cyc();
    drain_limit = 3'd7;
    push(0, 12, 'h84);
    push(1, 13, 'h85);
    push(2, 14, 'h86);
    push(3, 15, 'h87);
    @(negedge clk);
    chk("drain_count4", int'(count), 4);
    chk("drain_ready4", int'(bus.enq_ready_o), 1);
    cyc();
    @(negedge clk);
    chk("drain_empty", int'(empty), 1);

    // Reset mid-operation with six pending entries.
    cyc();
    drain_limit = 3'd0;
    drive(4'hF, 16'h4321, 32'hC3C2C1C0);
    cyc();
    drive(4'b0011, 16'h0065, 32'h0000C5C4);
    cyc();
    drive(4'h0, 16'h0, 32'h0);
    reset = 1'b1;
    drain_limit = 3'd4;
    @(negedge clk);
    chk("pre_reset_count", int'(count), 6);
    chk("reset_cycle_we", int'(we_v), 0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_count", int'(count), 0);
    chk("post_reset_empty", int'(empty), 1);
    repeat (3) begin
      cyc();
      @(negedge clk);
      chk("post_reset_we", int'(we_v), 0);
    end

    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
